tt_sweep_checker: RTL and testbench



---
 rtl/tt_pkg.sv | 20 ++
 rtl/tt_sweep_checker_if.sv | 28 ++
 rtl/tt_settle_timer.sv | 27 ++
 rtl/tt_sweep_checker.sv | 99 +++++++++
 tb/tb_tt_sweep_checker.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int MAX_N_IN = 4;

    // Number of input vectors a sweep visits for a given input width.
    function automatic int n_vec(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/tt_sweep_checker_if.sv
// Stimulus/response bundle between the sweep checker and its environment.
// Latency: n/a (wires only).
// Backpressure: none; start is a level, status outputs are held registers.
interface tt_sweep_checker_if #(
    parameter int N_IN = 4
);
    logic            start;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail;
    logic            first_fail_valid;

    // Environment side: kicks the sweep and provides the DUT response.
    modport master (
        output start, dut_out,
        input  dut_in, busy, done, pass, err_count, first_fail, first_fail_valid
    );

    // Checker side.
    modport slave (
        input  start, dut_out,
        output dut_in, busy, done, pass, err_count, first_fail, first_fail_valid
    );
endinterface

// File: rtl/tt_settle_timer.sv
// Counts enabled cycles and strobes expire on the SETTLE-th one.
// Latency: expire is high in the SETTLE-th consecutive enabled cycle.
// Backpressure: none; clear restarts the count from zero.
module tt_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expire
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [CW-1:0] cnt;

    assign expire = en && (cnt == CW'(SETTLE - 1));

    // Count while enabled; wrap to zero on expiry so the next vector starts fresh.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= expire ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 2**N_IN input vectors into a combinational DUT and checks each response.
// Latency: done rises 2**N_IN*(SETTLE+1) cycles after the accepting start edge.
// Backpressure: start ignored while busy; results hold in DONE until the next start.
module tt_sweep_checker
    import tt_pkg::*;
#(
    parameter int          N_IN     = 4,
    parameter int          SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'h0000
) (
    input  logic                clk,
    input  logic                reset,
    tt_sweep_checker_if.slave   bus
);
    localparam int             IW    = N_IN + 1;
    localparam int             N_VEC = n_vec(N_IN);
    localparam logic [IW-1:0]  LAST  = IW'(N_VEC - 1);

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   err_count;
    logic [N_IN-1:0] first_fail;
    logic            first_fail_valid;
    logic            go;
    logic            expire;
    logic            exp_bit;
    logic            mismatch;

    // A new sweep may only be launched from a resting state.
    assign go       = bus.start && ((state == IDLE) || (state == DONE));
    assign exp_bit  = |(EXPECTED & (16'd1 << idx));
    assign mismatch = (bus.dut_out != exp_bit);

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk    (clk),
        .reset  (reset),
        .clear  (go),
        .en     (state == DRIVE),
        .expire (expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: hold each vector SETTLE cycles, sample once, stop after the last.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = DRIVE;
            DRIVE:   if (expire)    state_nxt = SAMPLE;
            SAMPLE:  state_nxt = (idx == LAST) ? DONE : DRIVE;
            DONE:    if (bus.start) state_nxt = DRIVE;
            default: state_nxt = IDLE;
        endcase
    end

    // Vector index and result capture; a restart wipes the previous result.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx              <= '0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else if (go) begin
            idx              <= '0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else if (state == SAMPLE) begin
            if (mismatch) begin
                err_count <= err_count + 1'b1;
                if (!first_fail_valid) begin
                    first_fail       <= idx[N_IN-1:0];
                    first_fail_valid <= 1'b1;
                end
            end
            if (idx != LAST) begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign bus.dut_in           = idx[N_IN-1:0];
    assign bus.busy             = (state == DRIVE) || (state == SAMPLE);
    assign bus.done             = (state == DONE);
    assign bus.pass             = (state == DONE) && (err_count == '0);
    assign bus.err_count        = err_count;
    assign bus.first_fail       = first_fail;
    assign bus.first_fail_valid = first_fail_valid;
endmodule

// File: tb/tb_tt_sweep_checker.sv
// Three checker configurations side by side against a timeline-based reference model.
// A: N_IN=3 SETTLE=1 XOR with injectable faults; B: N_IN=4 all-ones vs tied-0; C: N_IN=2 SETTLE=3 delayed XOR.
// Shared clock, reset and start.
module tb_tt_sweep_checker;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] mask;
    bit         mon_en;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    tt_sweep_checker_if #(.N_IN(3)) if_a ();
    tt_sweep_checker_if #(.N_IN(4)) if_b ();
    tt_sweep_checker_if #(.N_IN(2)) if_c ();

    tt_sweep_checker #(.N_IN(3), .SETTLE(1), .EXPECTED(16'h0096))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    tt_sweep_checker #(.N_IN(4), .SETTLE(1), .EXPECTED(16'hFFFF))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    tt_sweep_checker #(.N_IN(2), .SETTLE(3), .EXPECTED(16'h0006))
        dut_c (.clk(clk), .reset(reset), .bus(if_c));

    // Circuits under test.
    logic c_d1, c_d2;
    always @(posedge clk) begin
        c_d1 <= ^if_c.dut_in;
        c_d2 <= c_d1;
    end
    assign if_a.start   = start;
    assign if_b.start   = start;
    assign if_c.start   = start;
    assign if_a.dut_out = (^if_a.dut_in) ^ mask[if_a.dut_in];
    assign if_b.dut_out = 1'b0;
    assign if_c.dut_out = c_d2;

    // ---------------- reference model ----------------
    localparam int NV [3] = '{8, 16, 4};
    localparam int ST [3] = '{1, 1, 3};
    int        cyc = 0;
    bit        started [3];
    int        k0 [3];
    bit [15:0] mis_snap [3];

    // Does the circuit of instance i disagree with its table on vector j?
    function automatic bit mis(input int i, input int j, input logic [7:0] m);
        logic [15:0] tbl;
        logic [3:0]  v;
        bit          resp;
        v    = j[3:0];
        tbl  = (i == 0) ? 16'h0096 : (i == 1) ? 16'hFFFF : 16'h0006;
        resp = (i == 1) ? 1'b0 : (^v);
        if (i == 0) resp = resp ^ m[v[2:0]];
        return resp != tbl[j];
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                started[i] = 1'b0;
            end else if (start && !(started[i] && (cyc - 1 - k0[i]) < NV[i] * (ST[i] + 1))) begin
                started[i] = 1'b1;
                k0[i]      = cyc;
                mis_snap[i] = '0;
                for (int j = 0; j < NV[i]; j++) mis_snap[i][j] = mis(i, j, mask);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_inst(input int i, input string nm, input int din, input int busy,
                              input int done, input int pass, input int err, input int ff,
                              input int ffv);
        int e, l, ns, x_din, x_busy, x_done, x_err, x_ff, x_ffv;
        x_din = 0; x_busy = 0; x_done = 0; x_err = 0; x_ff = 0; x_ffv = 0; ns = 0;
        if (started[i]) begin
            e = cyc - k0[i];
            l = NV[i] * (ST[i] + 1);
            if (e < l) begin
                x_busy = 1; x_din = e / (ST[i] + 1); ns = x_din;
            end else begin
                x_done = 1; x_din = NV[i] - 1; ns = NV[i];
            end
            for (int j = 0; j < ns; j++) begin
                if (mis_snap[i][j]) begin
                    x_err++;
                    if (x_ffv == 0) begin x_ff = j; x_ffv = 1; end
                end
            end
        end
        chk({nm, ".dut_in"}, din, x_din);
        chk({nm, ".busy"}, busy, x_busy);
        chk({nm, ".done"}, done, x_done);
        chk({nm, ".pass"}, pass, int'(x_done == 1 && x_err == 0));
        chk({nm, ".err_count"}, err, x_err);
        chk({nm, ".first_fail"}, ff, x_ff);
        chk({nm, ".first_fail_valid"}, ffv, x_ffv);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            check_inst(0, "a", int'(if_a.dut_in), int'(if_a.busy), int'(if_a.done), int'(if_a.pass),
                       int'(if_a.err_count), int'(if_a.first_fail), int'(if_a.first_fail_valid));
            check_inst(1, "b", int'(if_b.dut_in), int'(if_b.busy), int'(if_b.done), int'(if_b.pass),
                       int'(if_b.err_count), int'(if_b.first_fail), int'(if_b.first_fail_valid));
            check_inst(2, "c", int'(if_c.dut_in), int'(if_c.busy), int'(if_c.done), int'(if_c.pass),
                       int'(if_c.err_count), int'(if_c.first_fail), int'(if_c.first_fail_valid));
        end
    end

    // Launch one sweep with a start pulse of the given width; report edges to done.
    task automatic run_once(input int width, output int na, output int nb, output int nc);
        na = -1; nb = -1; nc = -1;
        start = 1'b1;
        @(negedge clk);
        if (width <= 1) start = 1'b0;
        for (int t = 1; t <= 100 && (na < 0 || nb < 0 || nc < 0); t++) begin
            @(negedge clk);
            if (t >= width - 1) start = 1'b0;
            if (na < 0 && if_a.done) na = t;
            if (nb < 0 && if_b.done) nb = t;
            if (nc < 0 && if_c.done) nc = t;
        end
        start = 1'b0;
    endtask

    int na, nb, nc, n;

    initial begin
        reset = 1'b1; start = 1'b0; mask = 8'h00; mon_en = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        chk("rst.a.busy", int'(if_a.busy), 0);
        chk("rst.a.err", int'(if_a.err_count), 0);
        chk("rst.b.done", int'(if_b.done), 0);
        reset = 1'b0;
        @(negedge clk);

        // Clean XOR sweep.
        run_once(1, na, nb, nc);
        chk("lat.a", na, 16);
        chk("lat.b", nb, 32);
        chk("lat.c", nc, 16);
        chk("clean.a.pass", int'(if_a.pass), 1);
        chk("clean.a.err", int'(if_a.err_count), 0);
        chk("clean.a.ffv", int'(if_a.first_fail_valid), 0);
        chk("tied0.b.err", int'(if_b.err_count), 16);
        chk("tied0.b.ff", int'(if_b.first_fail), 0);
        chk("tied0.b.pass", int'(if_b.pass), 0);
        chk("delay.c.pass", int'(if_c.pass), 1);

        // Vector 5 inverted.
        mask = 8'h20;
        repeat (2) @(negedge clk);
        run_once(1, na, nb, nc);
        chk("v5.a.err", int'(if_a.err_count), 1);
        chk("v5.a.ff", int'(if_a.first_fail), 5);
        chk("v5.a.ffv", int'(if_a.first_fail_valid), 1);
        chk("v5.a.pass", int'(if_a.pass), 0);

        // Random fault patterns and start pulse widths.
        for (int r = 0; r < 6; r++) begin
            mask = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_once($urandom_range(1, 4), na, nb, nc);
            chk("rnd.lat.a", na, 16);
            chk("rnd.lat.b", nb, 32);
        end

        // Reset mid-sweep while vector 3 is driven.
        mask = 8'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(if_a.dut_in == 3'd3 && if_a.busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("wait.idx3", n, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort.a.busy", int'(if_a.busy), 0);
        chk("abort.a.dut_in", int'(if_a.dut_in), 0);
        chk("abort.a.err", int'(if_a.err_count), 0);
        chk("abort.b.busy", int'(if_b.busy), 0);
        repeat (40) @(negedge clk);
        chk("abort.a.done", int'(if_a.done), 0);
        chk("abort.c.done", int'(if_c.done), 0);

        // Start held high: ignored while busy, immediate restart from DONE.
        mask = 8'h20;
        start = 1'b1;
        n = 0;
        while (!if_a.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("held.a.err_at_done", int'(if_a.err_count), 1);
        @(negedge clk);
        chk("held.a.restart_err", int'(if_a.err_count), 0);
        chk("held.a.restart_dut_in", int'(if_a.dut_in), 0);
        chk("held.a.restart_busy", int'(if_a.busy), 1);
        repeat (40) @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(if_a.done && if_b.done && if_c.done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("final.all_done", int'(if_a.done && if_b.done && if_c.done), 1);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
